// File: rtl/timer_irq_unit_pkg.sv
// Shared definitions for the timer/interrupt block: register map layout and
// TCON bit positions used by both the channel and the top-level decode.
package timer_irq_unit_pkg;

  // Register selector within one channel block (word offset 0..3)
  typedef enum logic [1:0] {
    REG_TH    = 2'd0,
    REG_TL    = 2'd1,
    REG_TCON  = 2'd2,
    REG_PRESC = 2'd3
  } reg_sel_e;

  // TCON bit positions
  localparam int TCON_EN     = 0;
  localparam int TCON_IE     = 1;
  localparam int TCON_STATUS = 2;
  localparam int TCON_MODE   = 3;

  // Channel register block stride in bytes and in words
  localparam int CH_STRIDE = 16;
  localparam int CH_WORDS  = CH_STRIDE / 4;

  // Byte offset of the global PEND register from the channel 0 base
  function automatic int pend_offset(input int num_ch);
    return CH_STRIDE * num_ch;
  endfunction

endpackage

// File: rtl/timer_irq_unit_timer_channel.sv
// One timer channel: TH/TL/TCON/PRESC registers, prescaler, up-counter and
// terminal-count handling. Bus writes arrive as pre-decoded strobes.
module timer_channel
  import timer_irq_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_th,
  input  logic               wr_tl,
  input  logic               wr_tcon,
  input  logic               wr_presc,
  input  logic [31:0]        wdata,
  output logic [WIDTH-1:0]   th,
  output logic [WIDTH-1:0]   tl,
  output logic [PRESC_W-1:0] presc,
  output logic [3:0]         tcon,
  output logic               pend
);

  localparam logic [WIDTH-1:0]   TL_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   TL_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PCNT_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]   th_q, th_d, tl_q, tl_d;
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic               en_q, en_d, ie_q, ie_d, status_q, status_d, mode_q, mode_d;
  logic               tick_s, term_s;

  // Next-state: prescaler tick, counter/reload, TCON with hardware-wins collisions
  always_comb begin
    tick_s  = en_q && (pcnt_q == presc_q);
    term_s  = 1'b0;
    th_d    = wr_th ? wdata[WIDTH-1:0] : th_q;
    presc_d = wr_presc ? wdata[PRESC_W-1:0] : presc_q;

    // A bus write to TL suppresses both the increment and the terminal event
    if (wr_tl) begin
      tl_d = wdata[WIDTH-1:0];
    end else if (tick_s && (tl_q == TL_MAX)) begin
      tl_d   = th_q;
      term_s = 1'b1;
    end else if (tick_s) begin
      tl_d = tl_q + TL_ONE;
    end else begin
      tl_d = tl_q;
    end

    // Terminal count overrides the written EN (one-shot) and STATUS (W1C)
    ie_d     = wr_tcon ? wdata[TCON_IE] : ie_q;
    mode_d   = wr_tcon ? wdata[TCON_MODE] : mode_q;
    en_d     = (wr_tcon ? wdata[TCON_EN] : en_q) & ~(term_s & mode_q);
    status_d = (wr_tcon ? (status_q & ~wdata[TCON_STATUS]) : status_q) | term_s;

    // Prescale counter sits at 0 whenever the channel is (or is becoming) idle
    if (!en_q || !en_d || wr_presc || tick_s) begin
      pcnt_d = {PRESC_W{1'b0}};
    end else begin
      pcnt_d = pcnt_q + PCNT_ONE;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q     <= {WIDTH{1'b0}};
      tl_q     <= {WIDTH{1'b0}};
      presc_q  <= {PRESC_W{1'b0}};
      pcnt_q   <= {PRESC_W{1'b0}};
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      status_q <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      th_q     <= th_d;
      tl_q     <= tl_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      status_q <= status_d;
      mode_q   <= mode_d;
    end
  end

  assign th    = th_q;
  assign tl    = tl_q;
  assign presc = presc_q;
  assign tcon  = {mode_q, status_q, ie_q, en_q};
  assign pend  = status_q & ie_q;

endmodule

// File: rtl/timer_irq_unit.sv
// Memory-mapped multi-channel timer: address decode, read mux, channel array
// and a registered lowest-index-first interrupt encoder.
module timer_irq_unit
  import timer_irq_unit_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter int          PRESC_W   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h40000020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [2:0]  irq_id
);

  // Word offset of PEND; channel registers occupy the words below it
  localparam logic [29:0] CH_SPAN = 30'(pend_offset(NUM_CH) / 4);

  logic [29:0]        off_s;
  logic               ch_hit_s, pend_hit_s;
  logic [2:0]         ch_idx_s;
  reg_sel_e           reg_sel_s;
  logic [NUM_CH-1:0]  wr_th_s, wr_tl_s, wr_tcon_s, wr_presc_s, pend_s;
  logic [WIDTH-1:0]   th_s [NUM_CH];
  logic [WIDTH-1:0]   tl_s [NUM_CH];
  logic [PRESC_W-1:0] presc_s [NUM_CH];
  logic [3:0]         tcon_s [NUM_CH];
  logic [WIDTH-1:0]   sel_th_s, sel_tl_s;
  logic [PRESC_W-1:0] sel_presc_s;
  logic [3:0]         sel_tcon_s;
  logic               irq_q, irq_d;
  logic [2:0]         irq_id_q, irq_id_d;
  logic               unused_addr_s;

  // Byte lane bits do not take part in decode
  assign unused_addr_s = ^addr[1:0];

  // Address decode relative to the channel 0 base (below-base addresses wrap high)
  always_comb begin
    off_s      = addr[31:2] - BASE_ADDR[31:2];
    ch_hit_s   = (off_s < CH_SPAN);
    pend_hit_s = (off_s == CH_SPAN);
    ch_idx_s   = off_s[4:2];
    reg_sel_s  = reg_sel_e'(off_s[1:0]);
  end

  // Per-channel write strobes
  always_comb begin
    wr_th_s    = {NUM_CH{1'b0}};
    wr_tl_s    = {NUM_CH{1'b0}};
    wr_tcon_s  = {NUM_CH{1'b0}};
    wr_presc_s = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr && ch_hit_s && (ch_idx_s == 3'(c))) begin
        case (reg_sel_s)
          REG_TH:    wr_th_s[c]    = 1'b1;
          REG_TL:    wr_tl_s[c]    = 1'b1;
          REG_TCON:  wr_tcon_s[c]  = 1'b1;
          REG_PRESC: wr_presc_s[c] = 1'b1;
          default:   wr_th_s[c]    = 1'b0;
        endcase
      end else begin
        wr_th_s[c] = 1'b0;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    timer_channel #(
      .WIDTH   (WIDTH),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_th    (wr_th_s[c]),
      .wr_tl    (wr_tl_s[c]),
      .wr_tcon  (wr_tcon_s[c]),
      .wr_presc (wr_presc_s[c]),
      .wdata    (wdata),
      .th       (th_s[c]),
      .tl       (tl_s[c]),
      .presc    (presc_s[c]),
      .tcon     (tcon_s[c]),
      .pend     (pend_s[c])
    );
  end

  // Select the addressed channel's register values
  always_comb begin
    sel_th_s    = {WIDTH{1'b0}};
    sel_tl_s    = {WIDTH{1'b0}};
    sel_presc_s = {PRESC_W{1'b0}};
    sel_tcon_s  = 4'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_th_s    = (ch_idx_s == 3'(c)) ? th_s[c]    : sel_th_s;
      sel_tl_s    = (ch_idx_s == 3'(c)) ? tl_s[c]    : sel_tl_s;
      sel_presc_s = (ch_idx_s == 3'(c)) ? presc_s[c] : sel_presc_s;
      sel_tcon_s  = (ch_idx_s == 3'(c)) ? tcon_s[c]  : sel_tcon_s;
    end
  end

  // Combinational read data, zero when not reading or unmapped
  always_comb begin
    rdata = 32'h0;
    if (rd && ch_hit_s) begin
      case (reg_sel_s)
        REG_TH:    rdata[WIDTH-1:0]   = sel_th_s;
        REG_TL:    rdata[WIDTH-1:0]   = sel_tl_s;
        REG_TCON:  rdata[3:0]         = sel_tcon_s;
        REG_PRESC: rdata[PRESC_W-1:0] = sel_presc_s;
        default:   rdata              = 32'h0;
      endcase
    end else if (rd && pend_hit_s) begin
      rdata[NUM_CH-1:0] = pend_s;
      rdata[10:8]       = irq_id_q;
    end else begin
      rdata = 32'h0;
    end
  end

  // Priority encoder: lowest pending channel wins, id is 0 when nothing pends
  always_comb begin
    irq_d    = |pend_s;
    irq_id_d = 3'd0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      irq_id_d = pend_s[c] ? 3'(c) : irq_id_d;
    end
  end

  // Registered interrupt outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q    <= 1'b0;
      irq_id_q <= 3'd0;
    end else begin
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
    end
  end

  assign irq    = irq_q;
  assign irq_id = irq_id_q;

endmodule
